// File: rtl/cmult_pipe.sv
// Pipelined complex multiplier, three multiplies (Gauss form), valid/ready flow.
// Ports: clk, rst, in_valid/in_ready, a_*, b_*, conj, out_valid/out_ready, m_*, ovf.
// Macro CMULT_SAT_EN: saturate out-of-range results; otherwise they wrap.
module cmult_pipe #(
   parameter int WIDTH = 14,
   parameter int FRAC  = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] a_re,
   input  logic signed [WIDTH-1:0] a_im,
   input  logic signed [WIDTH-1:0] b_re,
   input  logic signed [WIDTH-1:0] b_im,
   input  logic                    conj,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] m_re,
   output logic signed [WIDTH-1:0] m_im,
   output logic                    ovf
);

   localparam int PW = 2*WIDTH + 6;
   localparam logic signed [PW-1:0] RND =
      {{(PW-1){1'b0}}, 1'b1} << (FRAC-1);

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // stage 1 inputs: B widened so that negating -2^(WIDTH-1) is exact
   logic signed [WIDTH:0]   bre_e, bim_e, bim_c;
   logic signed [WIDTH+1:0] sa_c, sb_c;

   assign bre_e = {b_re[WIDTH-1], b_re};
   assign bim_e = {b_im[WIDTH-1], b_im};
   assign bim_c = conj ? -bim_e : bim_e;
   assign sa_c  = {{2{a_re[WIDTH-1]}}, a_re}
                + {{2{a_im[WIDTH-1]}}, a_im};
   assign sb_c  = {bre_e[WIDTH], bre_e}
                + {bim_c[WIDTH], bim_c};

   logic                    v1, v2;
   logic signed [WIDTH-1:0] s1_ar, s1_ai;
   logic signed [WIDTH:0]   s1_br, s1_bi;
   logic signed [WIDTH+1:0] s1_sa, s1_sb;
   logic signed [PW-1:0]    s2_p1, s2_p2, s2_p3;

   // stage 3 combinational: combine, round half-up, reduce
   logic signed [PW-1:0]    re_f, im_f, re_s, im_s;
   logic signed [WIDTH-1:0] re_q, im_q;
   logic                    ovf_q;

   function automatic logic oor(input logic signed [PW-1:0] x);
      // in range iff every bit above the result sign bit matches it
      return !((&x[PW-1:WIDTH-1]) || !(|x[PW-1:WIDTH-1]));
   endfunction

   function automatic logic [WIDTH-1:0] reduce(
      input logic signed [PW-1:0] x
   );
`ifdef CMULT_SAT_EN
      if (oor(x))
         return x[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                        : {1'b0, {(WIDTH-1){1'b1}}};
      return x[WIDTH-1:0];
`else
      return x[WIDTH-1:0];
`endif
   endfunction

   assign re_f  = s2_p1 - s2_p2;
   assign im_f  = s2_p3 - s2_p1 - s2_p2;
   assign re_s  = (re_f + RND) >>> FRAC;
   assign im_s  = (im_f + RND) >>> FRAC;
   assign re_q  = reduce(re_s);
   assign im_q  = reduce(im_s);
   assign ovf_q = oor(re_s) || oor(im_s);

   // control and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         m_re      <= '0;
         m_im      <= '0;
         ovf       <= 1'b0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         m_re      <= v2 ? re_q : '0;
         m_im      <= v2 ? im_q : '0;
         ovf       <= v2 ? ovf_q : 1'b0;
      end
   end

   // data path, no reset needed
   always_ff @(posedge clk) begin
      if (en) begin
         s1_ar <= a_re;
         s1_ai <= a_im;
         s1_br <= bre_e;
         s1_bi <= bim_c;
         s1_sa <= sa_c;
         s1_sb <= sb_c;
         s2_p1 <= PW'(s1_ar) * PW'(s1_br);
         s2_p2 <= PW'(s1_ai) * PW'(s1_bi);
         s2_p3 <= PW'(s1_sa) * PW'(s1_sb);
      end
   end

endmodule
